// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, byte-lane selectors and the default access latency.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

    localparam int unsigned DEFAULT_LATENCY = 2;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between the register-file side and the data memory.
// The master modport is the requester; the slave modport is the memory responder.
interface data_mem_responder_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_byte;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_byte, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_byte, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/dm_byte_lane.sv
// Combinational byte-lane helper: extracts a sign-extended load byte and
// builds the merged word for a store (byte stores replace one lane only).
module dm_byte_lane
    import data_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic        byte_en,
    input  logic [31:0] wdata,
    output logic [31:0] load_byte,
    output logic [31:0] store_word
);

    logic [7:0] sel;

    always_comb begin
        sel        = word[7:0];
        store_word = wdata;
        case (lane)
            LANE_0: sel = word[7:0];
            LANE_1: sel = word[15:8];
            LANE_2: sel = word[23:16];
            LANE_3: sel = word[31:24];
            default: sel = word[7:0];
        endcase
        if (byte_en) begin
            store_word = word;
            case (lane)
                LANE_0: store_word[7:0]   = wdata[7:0];
                LANE_1: store_word[15:8]  = wdata[7:0];
                LANE_2: store_word[23:16] = wdata[7:0];
                LANE_3: store_word[31:24] = wdata[7:0];
                default: store_word[7:0]  = wdata[7:0];
            endcase
        end
        load_byte = {{24{sel[7]}}, sel};
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering one load/store request at a time
// after a programmable latency, with valid/ready handshakes on both sides.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned ADDR_W  = $clog2(DEPTH) + 2,
    parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);

    localparam int unsigned IDX_W = ADDR_W - 2;

    state_t state, state_next;

    logic [3:0]        cnt;
    logic              we_q;
    logic              byte_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       resp_data_q;
    logic              resp_err_q;
    logic [31:0]       mem [DEPTH];

    logic             accept;
    logic             execute;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             misaligned;
    logic [31:0]      cur_word;
    logic [31:0]      load_byte;
    logic [31:0]      store_word;

    assign idx        = addr_q[ADDR_W-1:2];
    assign lane       = addr_q[1:0];
    assign cur_word   = mem[idx];
    assign misaligned = !byte_q && (lane != LANE_0);

    dm_byte_lane u_lane (
        .word       (cur_word),
        .lane       (lane),
        .byte_en    (byte_q),
        .wdata      (wdata_q),
        .load_byte  (load_byte),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        execute    = 1'b0;
        case (state)
            IDLE: if (bus.req_valid) begin
                accept     = 1'b1;
                state_next = BUSY;
            end
            BUSY: if (cnt == '0) begin
                execute    = 1'b1;
                state_next = RESP;
            end
            RESP: if (bus.resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;

    // Memory reset to mem[i]=i also discards any uncommitted store.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[IDX_W'(i)] <= 32'(i);
            end
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                byte_q  <= bus.req_byte;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                cnt     <= 4'(LATENCY - 1);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end

            if (execute) begin
                if (misaligned) begin
                    resp_data_q <= '0;
                    resp_err_q  <= 1'b1;
                end else if (we_q) begin
                    mem[idx]    <= store_word;
                    resp_data_q <= '0;
                    resp_err_q  <= 1'b0;
                end else begin
                    resp_data_q <= byte_q ? load_byte : cur_word;
                    resp_err_q  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a transaction-level memory model is
// compared every cycle, and literal expectations pin the model's results.
module tb_data_mem_responder;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned LAT    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

    data_mem_responder #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Transaction-level model: a request is outstanding from acceptance until the
    // response is taken; the access takes effect LAT edges after acceptance.
    logic [31:0]       m_mem [DEPTH];
    bit                m_started = 0;
    bit                m_out     = 0;
    bit                m_resp    = 0;
    int                m_age     = 0;
    bit                m_we, m_byte;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_data    = '0;
    bit                m_err     = 0;
    int                cyc        = 0;
    int                n_accept   = 0;
    int                accept_cyc = 0;
    int                n_hs       = 0;
    int                hs_cyc     = 0;

    always @(posedge clk) begin
        int idx, sh;
        logic [7:0] b;
        cyc++;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = i;
            m_started = 1;
            m_out     = 0;
            m_resp    = 0;
            m_data    = '0;
            m_err     = 0;
        end else if (!m_out) begin
            if (bus.req_valid) begin
                m_we       = bus.req_we;
                m_byte     = bus.req_byte;
                m_addr     = bus.req_addr;
                m_wdata    = bus.req_wdata;
                m_out      = 1;
                m_resp     = 0;
                m_age      = 0;
                n_accept++;
                accept_cyc = cyc;
            end
        end else if (!m_resp) begin
            m_age++;
            if (m_age == LAT) begin
                idx = int'(m_addr) / 4;
                sh  = (int'(m_addr) % 4) * 8;
                b   = 8'(m_mem[idx] >> sh);
                if (!m_byte && (sh != 0)) begin
                    m_data = '0;
                    m_err  = 1;
                end else if (m_we) begin
                    if (m_byte)
                        m_mem[idx] = (m_mem[idx] & ~(32'hFF << sh)) | ({24'h0, m_wdata[7:0]} << sh);
                    else
                        m_mem[idx] = m_wdata;
                    m_data = '0;
                    m_err  = 0;
                end else begin
                    m_data = m_byte ? 32'($signed(b)) : m_mem[idx];
                    m_err  = 0;
                end
                m_resp = 1;
            end
        end else if (bus.resp_ready) begin
            m_out  = 0;
            m_resp = 0;
            n_hs++;
            hs_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("req_ready", 32'(bus.req_ready), 32'(!m_out));
            chk("resp_valid", 32'(bus.resp_valid), 32'(m_resp));
            if (m_resp) begin
                chk("resp_data", bus.resp_data, m_data);
                chk("resp_err", 32'(bus.resp_err), 32'(m_err));
            end
        end
    end

    task automatic drive_req(input bit we, input bit byt, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_byte  = byt;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    task automatic send(input bit we, input bit byt, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] wdata);
        int n0;
        n0 = n_accept;
        @(negedge clk);
        drive_req(we, byt, addr, wdata);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (n_accept != n0) break;
        end
        if (n_accept == n0) chk("accept_timeout", 32'(n_accept), 32'(n0 + 1));
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string name, input logic [31:0] exp_data, input bit exp_err);
        for (int k = 0; k < 40; k++) begin
            if (bus.resp_valid) break;
            @(negedge clk);
        end
        if (!bus.resp_valid) begin
            chk({name, "_timeout"}, 32'(bus.resp_valid), 32'd1);
        end else begin
            chk({name, "_data"}, bus.resp_data, exp_data);
            chk({name, "_err"}, 32'(bus.resp_err), 32'(exp_err));
            chk({name, "_latency"}, 32'(cyc - accept_cyc), 32'(LAT));
        end
    endtask

    task automatic txn(input bit we, input bit byt, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] wdata, input string name,
                       input logic [31:0] exp_data, input bit exp_err);
        send(we, byt, addr, wdata);
        wait_resp(name, exp_data, exp_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int h0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_byte   = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'h0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        rst = 1'b0;

        txn(0, 0, 7'h0C, 32'h0,        "ld_w_0c", 32'h00000003, 0);
        txn(1, 0, 7'h10, 32'hDEADBEEF, "st_w_10", 32'h00000000, 0);
        txn(0, 1, 7'h13, 32'h0,        "ld_b_13", 32'hFFFFFFDE, 0);
        txn(0, 1, 7'h11, 32'h0,        "ld_b_11", 32'hFFFFFFBE, 0);
        txn(0, 1, 7'h10, 32'h0,        "ld_b_10", 32'hFFFFFFEF, 0);
        txn(0, 0, 7'h10, 32'h0,        "ld_w_10", 32'hDEADBEEF, 0);
        txn(0, 0, 7'h06, 32'h0,        "ld_mis_06", 32'h00000000, 1);
        txn(0, 0, 7'h04, 32'h0,        "ld_w_04a", 32'h00000001, 0);
        txn(1, 1, 7'h05, 32'hAAAAAA7F, "st_b_05", 32'h00000000, 0);
        txn(0, 0, 7'h04, 32'h0,        "ld_w_04b", 32'h00007F01, 0);
        txn(0, 1, 7'h05, 32'h0,        "ld_b_05", 32'h0000007F, 0);
        txn(1, 0, 7'h06, 32'hFFFFFFFF, "st_mis_06", 32'h00000000, 1);
        txn(0, 0, 7'h04, 32'h0,        "ld_w_04c", 32'h00007F01, 0);

        // Back-pressure: response held for three cycles while a new request waits.
        send(0, 0, 7'h0C, 32'h0);
        for (int k = 0; k < 40 && !bus.resp_valid; k++) @(negedge clk);
        bus.resp_ready = 1'b0;
        drive_req(0, 0, 7'h14, 32'h0);
        n0 = n_accept;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_resp_data", bus.resp_data, 32'h00000003);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_no_accept", 32'(n_accept), 32'(n0));
        end
        h0 = n_hs;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_handshake", 32'(n_hs), 32'(h0 + 1));
        chk("bp_still_waiting", 32'(n_accept), 32'(n0));
        @(negedge clk);
        chk("bp_accept", 32'(n_accept), 32'(n0 + 1));
        chk("bp_accept_spacing", 32'(accept_cyc - hs_cyc), 32'd1);
        bus.req_valid = 1'b0;
        wait_resp("bp_next", 32'h00000005, 0);

        // Reset while BUSY drops the pending byte store.
        send(1, 1, 7'h08, 32'h00000055);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("abort_resp_data", bus.resp_data, 32'h0);
        chk("abort_resp_err", 32'(bus.resp_err), 32'd0);
        rst = 1'b0;
        txn(0, 0, 7'h08, 32'h0, "ld_w_08", 32'h00000002, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Word-organised data memory that answers load and store requests issued on the register-file side of the core. It is the responder end of the register-file/data-memory path: it accepts one request at a time, waits a programmable access latency, commits stores, and returns load data (sign-extended for byte loads) with a valid/ready handshake. It replaces the zero-latency memory model so the pipeline can be exercised against realistic memory timing and back-pressure.

## Interface
**Parameters**
- DEPTH, 32: number of 32-bit words. Must be a power of two.
- ADDR_W, $clog2(DEPTH)+2: byte-address width.
- LATENCY, 2: cycles from acceptance to response. Legal range is 1..15.

**Ports**
- clk  in  1  single clock. All state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_addr  in  ADDR_W  byte address. The memory is little-endian.
- req_wdata  in  32  store data. Byte stores use bits [7:0].
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_data  out  32  load result. Driven to 0 for stores and errors.
- resp_err  out  1  the access was misaligned.

## Operation
- **States:** IDLE, BUSY, RESP.
- **IDLE:**
  - req_ready=1.
  - When req_valid=1, the request is accepted. The responder latches we, byte, addr and wdata, loads cnt=LATENCY-1, and moves to BUSY.
- **BUSY:**
  - req_ready=0.
  - If cnt≠0, cnt decrements.
  - If cnt=0, the access executes, the result is latched into resp_data/resp_err, and the state moves to RESP.
- **RESP:**
  - resp_valid=1 and req_ready=0.
  - When resp_ready=1, the state returns to IDLE.
  - resp_data and resp_err hold stable until the response is accepted.
- **Access execution:**
  - Word index = addr[ADDR_W-1:2]; lane = addr[1:0].
  - A word access with lane≠0 sets resp_err=1 and resp_data=0. There is no memory write.
  - Load word: resp_data = mem[idx].
  - Load byte: resp_data = the selected byte, sign-extended from bit 7.
  - Store word: mem[idx] = wdata.
  - Store byte: only the selected byte lane of mem[idx] is replaced with wdata[7:0]. The other lanes are unchanged.
- **Reset:**
  - mem[i] = i for every word.
  - State goes to IDLE.
  - cnt, resp_data and resp_err are cleared to 0.
  - Any pending request is dropped, including a store that has not yet been committed.
- **Write-back of stores:** a store becomes visible in memory on the same edge that moves the FSM from BUSY to RESP. A later load always observes it.

## Timing
- **Output reset values:** req_ready=1, resp_valid=0, resp_data=0, resp_err=0. These take effect on the first edge with rst=1.
- **Acceptance:** a request is accepted at edge T0, where req_valid and req_ready are both 1.
- **Response timing:** resp_valid rises after edge T0+LATENCY. With LATENCY=1 it is visible in the cycle immediately after BUSY.
- **Throughput:** at most one request is outstanding.
  - Minimum spacing between accepted requests is LATENCY+2 cycles when resp_ready is tied high.
  - The next request can be accepted one cycle after the response handshake.
- **Outputs are registered:** req_ready and resp_valid decode from the state register only. There is no combinational path from any input to any output.
- **Handshake inputs:**
  - req_valid may drop without consequence while req_ready=0.
  - Request fields are sampled only at the acceptance edge.
- **rst during BUSY or RESP:** the transaction is aborted and the outputs are at their reset values on the next cycle.

## Structure
- **Package `data_mem_pkg`** contains:
  - the state enum (IDLE/BUSY/RESP);
  - the lane constants;
  - the default LATENCY.
- **Sub-module `dm_byte_lane`** is combinational. It takes (word, lane, byte, wdata) and produces:
  - the sign-extended load byte;
  - the merged store word.
- The top level holds the FSM, the latency counter and the memory array.

## Test plan
- After reset with LATENCY=2, load word at 0x0C. Expect resp_data=0x00000003, resp_err=0, and resp_valid after acceptance edge +2.
- Store word 0xDEADBEEF at 0x10, then issue three byte loads:
  - 0x13 returns 0xFFFFFFDE;
  - 0x11 returns 0xFFFFFFBE;
  - 0x10 returns 0xFFFFFFEF.
- Store byte 0x7F at 0x05, then load word at 0x04. Expect 0x00007F01.
- Load word at 0x06. Expect resp_err=1 and resp_data=0. A following load of 0x04 returns 0x00000001.
- Hold resp_ready=0 for 3 cycles during RESP while req_valid=1. Expect:
  - resp_valid and resp_data stable;
  - req_ready=0 and no request accepted;
  - acceptance one cycle after the response handshake.
- Store 0x55 at 0x08 and assert rst in BUSY. Expect all outputs at reset values. A following load of 0x08 returns 0x00000002.
